// File: rtl/cgol_pkg.sv
// Shared definitions for the Game of Life generation scheduler.
//   sched_state_t        - scheduler FSM state, 3-bit encoding
//   CGOL_TICK_CYCLES     - default idle cycles between running generations
//   CGOL_TIMEOUT_CYCLES  - default start-to-done budget for the engine
//   CGOL_GEN_W           - default generation counter width
package cgol_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    START     = 3'd2,
    COMPUTE   = 3'd3,
    SWAP      = 3'd4,
    ERROR     = 3'd5
  } sched_state_t;

  localparam int CGOL_TICK_CYCLES    = 12_000_000;
  localparam int CGOL_TIMEOUT_CYCLES = 2048;
  localparam int CGOL_GEN_W          = 16;

endpackage

// File: rtl/cgol_cycle_timer.sv
// Clearable up-counter with enable and terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count this cycle
//   count      : current count, 0 .. LIMIT-1
//   tc         : high while enabled and count == LIMIT-1
module cgol_cycle_timer
  import cgol_pkg::*;
#(
  parameter int  LIMIT = CGOL_TICK_CYCLES,
  localparam int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  assign tc = en && (count == LAST);

  // Wraps to zero after the terminal count so the counter never leaves
  // its legal range, even if the user keeps it enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cgol_gen_scheduler.sv
// Generation scheduler for the Game of Life engine: paces generations with a
// tick timer, pulses the engine start, waits for the engine done rise, then
// pulses a buffer swap and counts completed generations.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_run          : level, free-running generations
//   i_step         : pulse, one generation (taken only in IDLE with i_run=0)
//   i_done         : engine done level
//   i_clear_error  : pulse, leave ERROR
//   o_start        : one-cycle engine start pulse
//   o_swap         : one-cycle buffer-swap pulse to the memory controller
//   o_busy         : high in START, COMPUTE and SWAP
//   o_generation   : completed-generation count (wraps)
//   o_error        : timeout flag, held while in ERROR
//   o_state        : current FSM state, for debug/checkers
// Optional feature macro: CGOL_SCHED_TIMEOUT_EN enables the COMPUTE timeout
// and the ERROR state; without it COMPUTE waits indefinitely.
//
// Engine handshake: o_start is a single-cycle pulse; the engine answers by
// raising i_done and holding it until the next o_start. Only a 0->1 change
// of i_done observed while in COMPUTE completes a generation, so a done level
// left over from the previous generation (or from reset) is never mistaken
// for completion.
module cgol_gen_scheduler
  import cgol_pkg::*;
#(
  parameter int TICK_CYCLES    = CGOL_TICK_CYCLES,
  parameter int TIMEOUT_CYCLES = CGOL_TIMEOUT_CYCLES,
  parameter int GEN_W          = CGOL_GEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_done,
  input  logic             i_clear_error,
  output logic             o_start,
  output logic             o_swap,
  output logic             o_busy,
  output logic [GEN_W-1:0] o_generation,
  output logic             o_error,
  output sched_state_t     o_state
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  sched_state_t     state_q, state_d;
  logic             done_q;
  logic             done_rise;
  logic [GEN_W-1:0] gen_q;
  logic             tick_tc;
  logic             tmo_tc;
  logic [TICK_W-1:0] unused_tick_count;

  // Resets high so a done level held through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b1;
    end else begin
      done_q <= i_done;
    end
  end

  assign done_rise = i_done && !done_q;

  // Cleared whenever we are outside WAIT_TICK, so it reads zero on entry.
  cgol_cycle_timer #(.LIMIT(TICK_CYCLES)) u_tick_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != WAIT_TICK),
    .en    (state_q == WAIT_TICK),
    .count (unused_tick_count),
    .tc    (tick_tc)
  );

`ifdef CGOL_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] unused_tmo_count;

  cgol_cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == START),
    .en    (state_q == COMPUTE),
    .count (unused_tmo_count),
    .tc    (tmo_tc)
  );
`else
  logic unused_clear_error;
  assign unused_clear_error = i_clear_error;
  assign tmo_tc             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_run) begin
          state_d = WAIT_TICK;
        end else if (i_step) begin
          state_d = START;
        end
      end
      WAIT_TICK: begin
        // Dropping run abandons the wait; no generation is issued.
        if (!i_run) begin
          state_d = IDLE;
        end else if (tick_tc) begin
          state_d = START;
        end
      end
      START: begin
        state_d = COMPUTE;
      end
      COMPUTE: begin
        // The done edge is tested first so it wins a tie with the timeout.
        if (done_rise) begin
          state_d = SWAP;
        end else if (tmo_tc) begin
          state_d = ERROR;
        end
      end
      SWAP: begin
        state_d = i_run ? WAIT_TICK : IDLE;
      end
`ifdef CGOL_SCHED_TIMEOUT_EN
      ERROR: begin
        if (i_clear_error) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counts on entry to SWAP so o_swap and the new count appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= '0;
    end else if (state_q == COMPUTE && done_rise) begin
      gen_q <= gen_q + 1'b1;
    end
  end

  assign o_start      = (state_q == START);
  assign o_swap       = (state_q == SWAP);
  assign o_busy       = (state_q == START) || (state_q == COMPUTE) || (state_q == SWAP);
  assign o_generation = gen_q;
  assign o_state      = state_q;

`ifdef CGOL_SCHED_TIMEOUT_EN
  assign o_error = (state_q == ERROR);
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_cgol_gen_scheduler.sv
// Self-checking bench for cgol_gen_scheduler (TICK=8, TIMEOUT=16, GEN_W=4).
// Stimulus pushes expected start/swap/error events (kind, cycle, generation)
// into exp_q; a monitor pops and compares whenever the DUT pulses an output.
module tb_cgol_gen_scheduler;
  import cgol_pkg::*;

  localparam int TICK = 8;
  localparam int TMO  = 16;
  localparam int GW   = 4;
  localparam int CW   = 16;
  localparam int EW   = 2 + CW + GW;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_SWAP  = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  logic          clk           = 1'b0;
  logic          rst_n         = 1'b0;
  logic          i_run         = 1'b0;
  logic          i_step        = 1'b0;
  logic          i_clear_error = 1'b0;
  logic          i_done;
  logic          o_start;
  logic          o_swap;
  logic          o_busy;
  logic [GW-1:0] o_generation;
  logic          o_error;
  sched_state_t  o_state;

  // Engine model: drops done when it sees o_start, raises it eng_delay
  // cycles later (eng_delay=0: never completes). Manual override via man_done.
  logic eng_auto  = 1'b0;
  logic eng_done  = 1'b1;
  logic man_done  = 1'b1;
  int   eng_delay = 5;
  int   eng_cd    = 0;
  assign i_done = eng_auto ? eng_done : man_done;

  logic [CW-1:0] cyc = '0;
  logic [EW-1:0] exp_q[$];
  logic          err_prev = 1'b0;
  int            checks = 0;
  int            passes = 0;

  cgol_gen_scheduler #(
    .TICK_CYCLES    (TICK),
    .TIMEOUT_CYCLES (TMO),
    .GEN_W          (GW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (i_run),
    .i_step        (i_step),
    .i_done        (i_done),
    .i_clear_error (i_clear_error),
    .o_start       (o_start),
    .o_swap        (o_swap),
    .o_busy        (o_busy),
    .o_generation  (o_generation),
    .o_error       (o_error),
    .o_state       (o_state)
  );

  // ---------------- clock / cycle count ----------------
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic push_ev(input logic [1:0] kind, input int at, input logic [GW-1:0] gen);
    exp_q.push_back({kind, CW'(at), gen});
  endtask

  task automatic wait_cyc(input int t);
    while (int'(cyc) < t) @(negedge clk);
  endtask

  task automatic pulse_step();
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
  endtask

  task automatic see_event(input logic [1:0] kind);
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    got = {kind, cyc, o_generation};
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL event: got kind=%0d cyc=%0d gen=%0d, required no event",
               kind, cyc, o_generation);
    end else begin
      exp = exp_q.pop_front();
      if (got === exp) passes++;
      else $display("FAIL event: got kind=%0d cyc=%0d gen=%0d, required kind=%0d cyc=%0d gen=%0d",
                    got[EW-1 -: 2], got[GW +: CW], got[GW-1:0],
                    exp[EW-1 -: 2], exp[GW +: CW], exp[GW-1:0]);
    end
  endtask

  // ---------------- engine model ----------------
  initial forever begin
    @(negedge clk);
    if (o_start) begin
      eng_done = 1'b0;
      eng_cd   = eng_delay;
    end else if (eng_cd > 0) begin
      eng_cd--;
      if (eng_cd == 0) eng_done = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (o_start) see_event(EV_START);
      if (o_swap) see_event(EV_SWAP);
      if (o_error && !err_prev) see_event(EV_ERR);
    end
    err_prev = o_error;
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int            t;
    int            s0;
    int            last_start;
    logic [GW-1:0] g;

    // Reset with done held high by the engine.
    repeat (3) @(negedge clk);
    check("rst_state", o_state, IDLE);
    check("rst_start", o_start, 0);
    check("rst_swap", o_swap, 0);
    check("rst_busy", o_busy, 0);
    check("rst_error", o_error, 0);
    check("rst_gen", o_generation, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Done held high into COMPUTE: no completion until it falls and rises.
    t = int'(cyc);
    push_ev(EV_START, t + 1, 4'd0);
    pulse_step();
    wait_cyc(t + 6);
    check("held_done_no_swap", o_state, COMPUTE);
    man_done = 1'b0;
    wait_cyc(t + 8);
    push_ev(EV_SWAP, t + 9, 4'd1);
    man_done = 1'b1;
    wait_cyc(t + 11);
    check("held_done_idle", o_state, IDLE);

    // Single step with the engine model; second step in COMPUTE ignored.
    eng_delay = 5;
    eng_auto  = 1'b1;
    @(negedge clk);
    t = int'(cyc);
    push_ev(EV_START, t + 1, 4'd1);
    push_ev(EV_SWAP, t + 7, 4'd2);
    pulse_step();
    wait_cyc(t + 3);
    check("step_busy", o_busy, 1);
    pulse_step();
    wait_cyc(t + 10);
    check("step_idle", o_state, IDLE);
    check("step_gen", o_generation, 2);
    check("step_idle_busy", o_busy, 0);

    // Run dropped during WAIT_TICK: back to IDLE, no generation.
    t = int'(cyc);
    i_run = 1'b1;
    wait_cyc(t + 4);
    check("tick_wait_state", o_state, WAIT_TICK);
    i_run = 1'b0;
    wait_cyc(t + 20);
    check("tick_drop_idle", o_state, IDLE);

    // Run mode, 17 generations (count wraps 15->0), run dropped in COMPUTE
    // of the last one. i_run sampled on the next edge, then TICK cycles of
    // WAIT_TICK; period is TICK + 2 + 5 = 15 cycles.
    t  = int'(cyc);
    s0 = t + 1 + TICK;
    g  = 4'd2;
    for (int k = 0; k < 17; k++) begin
      push_ev(EV_START, s0 + 15 * k, g);
      g = g + 4'd1;
      push_ev(EV_SWAP, s0 + 15 * k + 6, g);
    end
    i_run = 1'b1;
    last_start = s0 + 15 * 16;
    wait_cyc(last_start + 2);
    check("run_compute", o_state, COMPUTE);
    i_run = 1'b0;
    wait_cyc(last_start + 30);
    check("run_drop_idle", o_state, IDLE);
    check("run_wrap_gen", o_generation, 3);

`ifdef CGOL_SCHED_TIMEOUT_EN
    // Engine never completes: error after timeout count 15, no swap.
    eng_delay = 0;
    t = int'(cyc);
    push_ev(EV_START, t + 1, 4'd3);
    push_ev(EV_ERR, t + 18, 4'd3);
    pulse_step();
    wait_cyc(t + 20);
    check("tmo_error", o_error, 1);
    check("tmo_state", o_state, ERROR);
    i_clear_error = 1'b1;
    @(negedge clk);
    i_clear_error = 1'b0;
    check("tmo_cleared", o_error, 0);
    check("tmo_idle", o_state, IDLE);

    // Done rise on the same cycle as the timeout: done wins.
    eng_delay = 16;
    t = int'(cyc);
    push_ev(EV_START, t + 1, 4'd3);
    push_ev(EV_SWAP, t + 18, 4'd4);
    pulse_step();
    wait_cyc(t + 22);
    check("tie_no_error", o_error, 0);
    check("tie_idle", o_state, IDLE);
    check("tie_gen", o_generation, 4);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
